sd_frame_sequencer: RTL and testbench

- Controller for the standard-deviation pipeline. Arbitrates two ping-pong pixel-frame buffers between the frame collector (writer) and the SD compute engine (reader).
- Sequences each frame through: start compute, wait for sum/divide done, wait fixed sqrt latency, latch result, serialise the 16-bit SD as two bytes to the output link.
- Sits between data collection, the SD datapath and the byte-wide output module.

---
 rtl/sd_pkg.sv | 30 +++
 rtl/sd_byte_tx.sv | 39 +++
 rtl/sd_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sd_frame_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the standard-deviation frame sequencer.
package sd_pkg;

    localparam int unsigned NUM_BUFS = 2;
    localparam int unsigned SD_W     = 16;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        FULL = 2'd1,
        BUSY = 2'd2
    } buf_state_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        CALC      = 3'd2,
        SQRT_WAIT = 3'd3,
        TX_LO     = 3'd4,
        TX_HI     = 3'd5
    } seq_state_t;

    // Add 0..2 to an 8-bit count, clamping at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = 9'(v) + 9'(n);
        return (s > 9'd255) ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/sd_byte_tx.sv
// Valid/ready serialiser: sends a 16-bit SD result as two bytes, low byte first.
module sd_byte_tx
    import sd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SD_W-1:0]   word,
    input  logic              ready,
    output logic              valid,
    output logic [BYTE_W-1:0] data
);

    logic [BYTE_W-1:0] hi_byte;
    logic              hi_phase;

    // data only moves on load or on a completed handshake, so it is stable under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            data     <= '0;
            hi_byte  <= '0;
            hi_phase <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            data     <= word[BYTE_W-1:0];
            hi_byte  <= word[2*BYTE_W-1:BYTE_W];
            hi_phase <= 1'b0;
        end else if (valid && ready) begin
            if (!hi_phase) begin
                data     <= hi_byte;
                hi_phase <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sd_frame_sequencer.sv
// Ping-pong buffer arbiter and compute/transmit sequencer for the SD pipeline.
// Optional watchdog on the CALC wait is enabled with `define SD_WATCHDOG_EN.
module sd_frame_sequencer
    import sd_pkg::*;
#(
    parameter int unsigned SQRT_LATENCY = 28,
    parameter int unsigned CALC_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coll_frame_done,
    output logic              coll_enable,
    output logic              coll_buf_sel,
    output logic              calc_start,
    output logic              calc_buf_sel,
    input  logic              calc_done,
    input  logic [SD_W-1:0]   sd_in,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt,
    output logic              busy,
    output logic              wdog_err
);

    localparam int unsigned CNT_MAX = (SQRT_LATENCY > CALC_TIMEOUT) ? SQRT_LATENCY : CALC_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(SQRT_LATENCY - 1);

    buf_state_t       buf_st [NUM_BUFS];
    buf_state_t       buf_n  [NUM_BUFS];
    logic             wr_sel;
    logic             wr_sel_n;
    logic             rd_sel;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic accept_c;
    logic drop_c;
    logic take_c;
    logic free_c;
    logic wdog_to_c;
    logic tx_load_c;
    logic tx_hs_c;

    assign coll_buf_sel = wr_sel;

    // Buffer next-state: collector, FSM take and FSM free may all land in one cycle
    always_comb begin
        buf_n    = buf_st;
        wr_sel_n = wr_sel;
        accept_c = coll_frame_done && coll_enable;
        drop_c   = coll_frame_done && !coll_enable;
        take_c   = (state == IDLE) && (buf_st[rd_sel] == FULL);
`ifdef SD_WATCHDOG_EN
        wdog_to_c = (state == CALC) && !calc_done && (cnt == CNT_W'(CALC_TIMEOUT - 1));
`else
        wdog_to_c = 1'b0;
`endif
        free_c    = ((state == CALC) && calc_done) || wdog_to_c;
        tx_load_c = (state == SQRT_WAIT) && (cnt == SQRT_LAST);
        tx_hs_c   = tx_valid && tx_ready;
        if (accept_c) begin
            buf_n[wr_sel] = FULL;
            wr_sel_n      = ~wr_sel;
        end
        if (take_c) begin
            buf_n[rd_sel] = BUSY;
        end
        if (free_c) begin
            buf_n[calc_buf_sel] = FREE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_st       <= '{default: FREE};
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            coll_enable  <= 1'b1;
            calc_start   <= 1'b0;
            calc_buf_sel <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            frame_cnt    <= '0;
            drop_cnt     <= '0;
            busy         <= 1'b0;
        end else begin
            buf_st      <= buf_n;
            wr_sel      <= wr_sel_n;
            coll_enable <= (buf_n[wr_sel_n] == FREE);
            drop_cnt    <= sat_add8(drop_cnt, 2'(drop_c) + 2'(wdog_to_c));
            calc_start  <= 1'b0;
            if (free_c) begin
                rd_sel <= ~rd_sel;
            end
            case (state)
                IDLE: begin
                    if (take_c) begin
                        calc_buf_sel <= rd_sel;
                        calc_start   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    if (calc_done) begin
                        cnt   <= '0;
                        state <= SQRT_WAIT;
                    end
`ifdef SD_WATCHDOG_EN
                    else if (wdog_to_c) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                // sd_in is valid SQRT_LATENCY edges after the calc_done edge
                SQRT_WAIT: begin
                    if (tx_load_c) begin
                        state <= TX_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_LO: begin
                    if (tx_hs_c) begin
                        state <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_hs_c) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SD_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_err <= 1'b0;
        end else if (wdog_to_c) begin
            wdog_err <= 1'b1;
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

    sd_byte_tx u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load_c),
        .word  (sd_in),
        .ready (tx_ready),
        .valid (tx_valid),
        .data  (tx_data)
    );

endmodule

// File: tb/tb_sd_frame_sequencer.sv
// Directed bench for sd_frame_sequencer with SQRT_LATENCY=4, CALC_TIMEOUT=20.
module tb_sd_frame_sequencer;

    logic        clk;
    logic        rst;
    logic        coll_frame_done;
    logic        coll_enable;
    logic        coll_buf_sel;
    logic        calc_start;
    logic        calc_buf_sel;
    logic        calc_done;
    logic [15:0] sd_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
    logic        busy;
    logic        wdog_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;

    sd_frame_sequencer #(
        .SQRT_LATENCY (4),
        .CALC_TIMEOUT (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .coll_frame_done (coll_frame_done),
        .coll_enable     (coll_enable),
        .coll_buf_sel    (coll_buf_sel),
        .calc_start      (calc_start),
        .calc_buf_sel    (calc_buf_sel),
        .calc_done       (calc_done),
        .sd_in           (sd_in),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt),
        .busy            (busy),
        .wdog_err        (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame();
        coll_frame_done = 1'b1;
        step();
        coll_frame_done = 1'b0;
    endtask

    // Bounded wait for calc_start, then confirm which buffer is being read
    task automatic wait_start(input logic exp_sel);
        for (int i = 0; i < 20 && calc_start !== 1'b1; i++) step();
        chk("calc_start", 16'(calc_start), 16'd1);
        chk("calc_buf_sel", 16'(calc_buf_sel), 16'(exp_sel));
        chk("busy_start", 16'(busy), 16'd1);
    endtask

    // From just after the calc_done edge: latency, both bytes, frame count
    task automatic tail_frame(input logic [15:0] sd);
        repeat (3) step();
        chk("sqrt_wait_valid", 16'(tx_valid), 16'd0);
        step();
        chk("lo_valid", 16'(tx_valid), 16'd1);
        chk("lo_data", 16'(tx_data), 16'(sd[7:0]));
        step();
        chk("hi_valid", 16'(tx_valid), 16'd1);
        chk("hi_data", 16'(tx_data), 16'(sd[15:8]));
        step();
        exp_frames++;
        chk("done_valid", 16'(tx_valid), 16'd0);
        chk("frame_cnt", frame_cnt, 16'(exp_frames));
        chk("busy_done", 16'(busy), 16'd0);
    endtask

    task automatic complete_frame(input logic [15:0] sd);
        sd_in     = sd;
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        tail_frame(sd);
    endtask

    initial begin
        rst             = 1'b1;
        coll_frame_done = 1'b0;
        calc_done       = 1'b0;
        sd_in           = '0;
        tx_ready        = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_coll_enable", 16'(coll_enable), 16'd1);
        chk("rst_coll_buf_sel", 16'(coll_buf_sel), 16'd0);
        chk("rst_calc_start", 16'(calc_start), 16'd0);
        chk("rst_calc_buf_sel", 16'(calc_buf_sel), 16'd0);
        chk("rst_tx_valid", 16'(tx_valid), 16'd0);
        chk("rst_tx_data", 16'(tx_data), 16'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_drop_cnt", 16'(drop_cnt), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_wdog_err", 16'(wdog_err), 16'd0);

        // Single frame, calc_done 10 cycles after calc_start
        pulse_frame();
        chk("s1_coll_buf_sel", 16'(coll_buf_sel), 16'd1);
        chk("s1_busy_idle", 16'(busy), 16'd0);
        wait_start(1'b0);
        step();
        chk("s1_start_pulse", 16'(calc_start), 16'd0);
        repeat (8) step();
        complete_frame(16'hA53C);

        // Backpressure on the low byte, then on the high byte
        pulse_frame();
        wait_start(1'b1);
        step();
        sd_in     = 16'hA53C;
        calc_done = 1'b1;
        tx_ready  = 1'b0;
        step();
        calc_done = 1'b0;
        repeat (4) step();
        chk("bp_valid", 16'(tx_valid), 16'd1);
        chk("bp_data", 16'(tx_data), 16'h3C);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 16'(tx_valid), 16'd1);
            chk("bp_hold_data", 16'(tx_data), 16'h3C);
        end
        tx_ready = 1'b1;
        step();
        chk("bp_hi_data", 16'(tx_data), 16'hA5);
        tx_ready = 1'b0;
        step();
        chk("bp_hi_hold_valid", 16'(tx_valid), 16'd1);
        chk("bp_hi_hold_data", 16'(tx_data), 16'hA5);
        tx_ready = 1'b1;
        step();
        exp_frames++;
        chk("bp_done_valid", 16'(tx_valid), 16'd0);
        chk("bp_frame_cnt", frame_cnt, 16'(exp_frames));

        // Overflow: three back-to-back frames, third one dropped
        coll_frame_done = 1'b1;
        step();
        chk("ov_en_after_1", 16'(coll_enable), 16'd1);
        step();
        chk("ov_en_after_2", 16'(coll_enable), 16'd0);
        chk("ov_start", 16'(calc_start), 16'd1);
        chk("ov_first_buf", 16'(calc_buf_sel), 16'd0);
        step();
        coll_frame_done = 1'b0;
        chk("ov_drop_cnt", 16'(drop_cnt), 16'd1);
        chk("ov_in_calc", 16'(calc_start), 16'd0);
        complete_frame(16'h1234);
        chk("ov_en_freed", 16'(coll_enable), 16'd1);
        chk("ov_wr_buf", 16'(coll_buf_sel), 16'd0);
        wait_start(1'b1);
        step();
        complete_frame(16'h00FF);
        chk("ov_drop_final", 16'(drop_cnt), 16'd1);

        // calc_done on buffer 0 together with collector finishing buffer 1
        pulse_frame();
        wait_start(1'b0);
        step();
        sd_in           = 16'hBEEF;
        calc_done       = 1'b1;
        coll_frame_done = 1'b1;
        step();
        calc_done       = 1'b0;
        coll_frame_done = 1'b0;
        chk("sim_coll_enable", 16'(coll_enable), 16'd1);
        chk("sim_coll_buf_sel", 16'(coll_buf_sel), 16'd0);
        chk("sim_no_drop", 16'(drop_cnt), 16'd1);
        tail_frame(16'hBEEF);
        wait_start(1'b1);
        step();
        complete_frame(16'h0102);

        // Asynchronous reset while a byte is being offered
        pulse_frame();
        wait_start(1'b0);
        step();
        sd_in     = 16'h5A5A;
        calc_done = 1'b1;
        tx_ready  = 1'b0;
        step();
        calc_done = 1'b0;
        repeat (4) step();
        chk("rtx_valid_before", 16'(tx_valid), 16'd1);
        rst = 1'b1;
        #1;
        chk("rtx_valid", 16'(tx_valid), 16'd0);
        chk("rtx_data", 16'(tx_data), 16'd0);
        chk("rtx_frame_cnt", frame_cnt, 16'd0);
        chk("rtx_drop_cnt", 16'(drop_cnt), 16'd0);
        chk("rtx_busy", 16'(busy), 16'd0);
        chk("rtx_coll_enable", 16'(coll_enable), 16'd1);
        chk("rtx_coll_buf_sel", 16'(coll_buf_sel), 16'd0);
        chk("rtx_calc_buf_sel", 16'(calc_buf_sel), 16'd0);
        exp_frames = 0;
        step();
        rst      = 1'b0;
        tx_ready = 1'b1;
        pulse_frame();
        wait_start(1'b0);
        step();
        complete_frame(16'hC001);

`ifdef SD_WATCHDOG_EN
        // calc_done withheld: buffer 1 is abandoned after 20 CALC cycles
        pulse_frame();
        wait_start(1'b1);
        step();
        repeat (19) step();
        chk("wd_err_before", 16'(wdog_err), 16'd0);
        chk("wd_busy_before", 16'(busy), 16'd1);
        step();
        chk("wd_err", 16'(wdog_err), 16'd1);
        chk("wd_drop_cnt", 16'(drop_cnt), 16'd1);
        chk("wd_busy", 16'(busy), 16'd0);
        chk("wd_tx_valid", 16'(tx_valid), 16'd0);
        pulse_frame();
        wait_start(1'b0);
        step();
        complete_frame(16'h7E81);
        chk("wd_err_sticky", 16'(wdog_err), 16'd1);
`else
        chk("wdog_err_off", 16'(wdog_err), 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
